// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the TPU control blocks.
// Holds the sequencer state encoding, default geometry and the step-counter width helper.
package tpu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_LANES  = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_ROWS_W = 8;

  // One spare bit above rows + lane skew, so N+LANES-1 always fits.
  function automatic int step_cnt_width(input int rows_w, input int lanes);
    return rows_w + $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/skew_rd_control_skew_lane.sv
// One lane of the skewed read pattern: lane LANE trails lane 0 by LANE steps.
// Purely combinational; the parent registers the results.
module skew_lane #(
  parameter int LANE   = 0,
  parameter int CNT_W  = 13,
  parameter int ROWS_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic [CNT_W-1:0]  k,
  input  logic [ROWS_W-1:0] n_rows,
  input  logic [ADDR_W-1:0] base,
  output logic              en,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [CNT_W-1:0] LANE_K = CNT_W'(LANE);

  logic [CNT_W-1:0] row_idx;

  assign row_idx = k - LANE_K;
  assign en      = (k >= LANE_K) && (row_idx < CNT_W'(n_rows));
  // Address wraps naturally at the address width.
  assign addr    = en ? (base + ADDR_W'(row_idx)) : '0;

endmodule

// File: rtl/skew_rd_control.sv
// Skewed multi-lane read controller: streams N rows per lane with lane i delayed by i cycles.
// All outputs are registered; the value loaded at each edge is the step being issued next.
module skew_rd_control
  import tpu_ctrl_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ROWS_W = DEF_ROWS_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ROWS_W-1:0]       num_rows,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [LANES-1:0]        rd_en,
  output logic [LANES*ADDR_W-1:0] rd_addr,
  output logic                    wr_active
);

  localparam int               CNT_W    = step_cnt_width(ROWS_W, LANES);
  localparam logic [CNT_W-1:0] TAIL_OFF = CNT_W'(LANES - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        k_reg, k_next;
  logic [ADDR_W-1:0]       base_reg, base_next;
  logic [ROWS_W-1:0]       rows_reg, rows_next;

  logic                    issue;
  logic [CNT_W-1:0]        k_issue;
  logic [ADDR_W-1:0]       base_sel;
  logic [ROWS_W-1:0]       rows_sel;
  logic                    busy_next, done_next;

  logic [LANES-1:0]        lane_en;
  logic [LANES*ADDR_W-1:0] lane_addr;

  logic                    busy_reg, done_reg, wr_active_reg;
  logic [LANES-1:0]        rd_en_reg;
  logic [LANES*ADDR_W-1:0] rd_addr_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      skew_lane #(
        .LANE   (gi),
        .CNT_W  (CNT_W),
        .ROWS_W (ROWS_W),
        .ADDR_W (ADDR_W)
      ) u_lane (
        .k      (k_issue),
        .n_rows (rows_sel),
        .base   (base_sel),
        .en     (lane_en[gi]),
        .addr   (lane_addr[gi*ADDR_W +: ADDR_W])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    base_next  = base_reg;
    rows_next  = rows_reg;
    issue      = 1'b0;
    k_issue    = k_reg;
    base_sel   = base_reg;
    rows_sel   = rows_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          if (num_rows != '0) begin
            // Step 0 goes out straight from the inputs being latched.
            base_next  = base_addr;
            rows_next  = num_rows;
            base_sel   = base_addr;
            rows_sel   = num_rows;
            k_issue    = '0;
            issue      = 1'b1;
            k_next     = CNT_W'(1);
            busy_next  = 1'b1;
            state_next = RUN;
          end else begin
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end

      RUN: begin
        if (stall) begin
          busy_next = 1'b1;
        end else if (k_reg == (CNT_W'(rows_reg) + TAIL_OFF)) begin
          // Last step (N+LANES-2) was issued on the previous edge.
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          issue     = 1'b1;
          k_next    = k_reg + CNT_W'(1);
          busy_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      base_reg      <= '0;
      rows_reg      <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rd_en_reg     <= '0;
      rd_addr_reg   <= '0;
      wr_active_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      base_reg      <= base_next;
      rows_reg      <= rows_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      rd_en_reg     <= issue ? lane_en : '0;
      rd_addr_reg   <= issue ? lane_addr : '0;
      wr_active_reg <= issue & lane_en[LANES-1];
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign rd_en     = rd_en_reg;
  assign rd_addr   = rd_addr_reg;
  assign wr_active = wr_active_reg;

endmodule

// File: tb/tb_skew_rd_control.sv
// Directed bench for skew_rd_control (LANES=4, ADDR_W=8): per-cycle tables of expected outputs.
// Addresses follow from the hand-written enable tables: each enabled cycle advances that lane's row.
module tb_skew_rd_control;

  localparam int LANES  = 4;
  localparam int ADDR_W = 8;
  localparam int ROWS_W = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [ADDR_W-1:0]       base_addr;
  logic [ROWS_W-1:0]       num_rows;
  logic                    stall;
  logic                    busy;
  logic                    done;
  logic [LANES-1:0]        rd_en;
  logic [LANES*ADDR_W-1:0] rd_addr;
  logic                    wr_active;

  int tests_run    = 0;
  int tests_failed = 0;

  // Nibble c of exp_en is rd_en in cycle t+c; bit c of the others likewise.
  logic [63:0] exp_en;
  logic [15:0] exp_busy, exp_done, exp_wr;
  logic [15:0] drv_stall, drv_reset, drv_start;
  logic [7:0]  drv_base [16];
  logic [7:0]  drv_n    [16];
  logic        chk_l0;
  logic [31:0] l0_tab;

  always #5 clk = ~clk;

  skew_rd_control #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W),
    .ROWS_W (ROWS_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .wr_active (wr_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_drv();
    drv_stall = '0;
    drv_reset = '0;
    drv_start = '0;
    chk_l0    = 1'b0;
    l0_tab    = '0;
    for (int i = 0; i < 16; i++) begin
      drv_base[i] = '0;
      drv_n[i]    = '0;
    end
  endtask

  // Starts a transfer at the coming edge t, then checks cycles t+1 .. t+ncyc.
  task automatic run(input string tag, input logic [7:0] base, input logic [7:0] n, input int ncyc);
    int          off [4];
    logic [3:0]  ee;
    logic [31:0] ea;
    for (int i = 0; i < 4; i++) off[i] = 0;
    start     = 1'b1;
    base_addr = base;
    num_rows  = n;
    stall     = 1'b0;
    reset     = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      ee = exp_en[c*4 +: 4];
      ea = '0;
      for (int i = 0; i < 4; i++) begin
        if (ee[i]) begin
          ea[i*8 +: 8] = base + 8'(off[i]);
          off[i]++;
        end
      end
      check($sformatf("%s c%0d rd_en", tag, c), 32'(rd_en), 32'(ee));
      check($sformatf("%s c%0d rd_addr", tag, c), rd_addr, ea);
      check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(exp_busy[c]));
      check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(exp_done[c]));
      check($sformatf("%s c%0d wr_active", tag, c), 32'(wr_active), 32'(exp_wr[c]));
      if (chk_l0 && c <= 4)
        check($sformatf("%s c%0d lane0_addr", tag, c), 32'(rd_addr[7:0]), 32'(l0_tab[(c-1)*8 +: 8]));
      if (exp_done[c]) begin
        for (int i = 0; i < 4; i++) off[i] = 0;
      end
      start     = drv_start[c];
      stall     = drv_stall[c];
      reset     = drv_reset[c];
      base_addr = drv_base[c];
      num_rows  = drv_n[c];
    end
    $display("[TB] %s: base=%h n=%0d, %0d cycles checked", tag, base, n, ncyc);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    stall     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset rd_en", 32'(rd_en), 32'h0);
    check("reset rd_addr", rd_addr, 32'h0);
    check("reset wr_active", 32'(wr_active), 32'h0);
    reset = 1'b0;

    // 1: base 0x10, N=3, no stall
    clear_drv();
    exp_en = 64'h008CE7310; exp_busy = 16'h007E; exp_wr = 16'h0070; exp_done = 16'h0080;
    run("s1", 8'h10, 8'd3, 8);

    // 2: stall sampled at two consecutive edges after step 1
    clear_drv();
    drv_stall[2] = 1'b1; drv_stall[3] = 1'b1;
    exp_en = 64'h008CE700310; exp_busy = 16'h01FE; exp_wr = 16'h01C0; exp_done = 16'h0200;
    run("s2", 8'h10, 8'd3, 10);

    // 3: N=0 goes straight to DONE
    clear_drv();
    exp_en = 64'h0; exp_busy = 16'h0; exp_wr = 16'h0; exp_done = 16'h0002;
    run("s3", 8'h33, 8'd0, 4);

    // 4: ignored start mid-run, then back-to-back start in the DONE cycle
    clear_drv();
    drv_start[2] = 1'b1; drv_base[2] = 8'h80; drv_n[2] = 8'd5;
    drv_start[7] = 1'b1; drv_base[7] = 8'h10; drv_n[7] = 8'd1;
    exp_en = 64'h00842108CE7310; exp_busy = 16'h0F7E; exp_wr = 16'h0870; exp_done = 16'h1080;
    run("s4", 8'h10, 8'd3, 13);

    // 5: reset sampled at edge t+3, then a clean rerun
    clear_drv();
    drv_reset[3] = 1'b1;
    exp_en = 64'h7310; exp_busy = 16'h000E; exp_wr = 16'h0; exp_done = 16'h0;
    run("s5", 8'h10, 8'd3, 10);
    clear_drv();
    exp_en = 64'h008CE7310; exp_busy = 16'h007E; exp_wr = 16'h0070; exp_done = 16'h0080;
    run("s5b", 8'h10, 8'd3, 8);

    // 6: address wrap, base 0xFE, N=4
    clear_drv();
    chk_l0 = 1'b1; l0_tab = 32'h0100FFFE;
    exp_en = 64'h008CEF7310; exp_busy = 16'h00FE; exp_wr = 16'h00F0; exp_done = 16'h0100;
    run("s6", 8'hFE, 8'd4, 9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
